// File: rtl/i2c_master_nbyte.sv
// Open-drain I2C register master: START, address, pointer, then DATA_BYTES data bytes (reads via repeated START).
// Each bus bit takes 4*CLK_DIV clocks; eot follows the STOP bit; start is ignored while busy.
module i2c_master_nbyte #(
    parameter int DATA_BYTES = 2,
    parameter int CLK_DIV    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    rd_wr,
    input  logic [6:0]              slv_addr_in,
    input  logic [7:0]              pointer_addr,
    input  logic [8*DATA_BYTES-1:0] data_in,
    output logic [8*DATA_BYTES-1:0] data_out,
    output logic                    busy,
    output logic                    eot,
    output logic                    nack,
    inout  wire                     sda,
    inout  wire                     scl
);

    localparam int W = 8 * DATA_BYTES;
    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_MAX = DIVW'(CLK_DIV - 1);
    localparam logic [1:0] LAST_BYTE = 2'(DATA_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, ACK1, PTR, ACK2, WDATA, ACK3,
        RSTART, ADDR_R, ACK4, RDATA, MACK, STOP, DONE
    } state_t;

    state_t          state, nxt_state;
    logic [1:0]      q, nxt_q;
    logic [DIVW-1:0] div_cnt, nxt_div;
    logic [2:0]      bit_cnt, nxt_bit;
    logic [1:0]      byte_cnt, nxt_byte;
    logic            hold;
    logic            rw_r;
    logic [6:0]      addr_r;
    logic [7:0]      ptr_r;
    logic [W-1:0]    wdat_r;
    logic [W-1:0]    rx_sh;
    logic            line_s;
    logic            sda_low, scl_low;
    logic            nxt_sda_low, nxt_scl_low;
    logic            nack_set;
    logic            active, q_end, bit_end, samp;
    logic [W-1:0]    wsh;
    logic [7:0]      tx_byte;
    logic            tx_bit;

    assign sda = sda_low ? 1'b0 : 1'bz;
    assign scl = scl_low ? 1'b0 : 1'bz;

    // hold stalls the divider for one clock after acceptance
    assign active  = (state != IDLE) && (state != DONE) && !hold;
    assign q_end   = active && (div_cnt == DIV_MAX);
    assign bit_end = q_end && (q == 2'd3);
    assign samp    = q_end && (q == 2'd2);

    always_comb begin
        nxt_state = state;
        nxt_bit   = bit_cnt;
        nxt_byte  = byte_cnt;
        nack_set  = 1'b0;
        nxt_q     = q_end ? q + 2'd1 : q;
        nxt_div   = div_cnt;
        if (active)
            nxt_div = (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
        if (state == DONE) begin
            nxt_state = IDLE;
        end else if (bit_end) begin
            unique case (state)
                START:  begin nxt_state = ADDR_W; nxt_bit = 3'd0; end
                RSTART: begin nxt_state = ADDR_R; nxt_bit = 3'd0; end
                ADDR_W, PTR, WDATA, ADDR_R, RDATA: begin
                    nxt_bit = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        unique case (state)
                            ADDR_W:  nxt_state = ACK1;
                            PTR:     nxt_state = ACK2;
                            WDATA:   nxt_state = ACK3;
                            ADDR_R:  nxt_state = ACK4;
                            default: nxt_state = MACK;
                        endcase
                    end
                end
                ACK1, ACK2, ACK3, ACK4: begin
                    nxt_bit = 3'd0;
                    if (line_s) begin
                        nack_set  = 1'b1;
                        nxt_state = STOP;
                    end else begin
                        unique case (state)
                            ACK1: nxt_state = PTR;
                            ACK2: begin
                                nxt_state = rw_r ? RSTART : WDATA;
                                nxt_byte  = 2'd0;
                            end
                            ACK3: begin
                                if (byte_cnt == LAST_BYTE) begin
                                    nxt_state = STOP;
                                end else begin
                                    nxt_state = WDATA;
                                    nxt_byte  = byte_cnt + 2'd1;
                                end
                            end
                            default: begin
                                nxt_state = RDATA;
                                nxt_byte  = 2'd0;
                            end
                        endcase
                    end
                end
                MACK: begin
                    nxt_bit = 3'd0;
                    if (byte_cnt == LAST_BYTE) begin
                        nxt_state = STOP;
                    end else begin
                        nxt_state = RDATA;
                        nxt_byte  = byte_cnt + 2'd1;
                    end
                end
                STOP:    nxt_state = DONE;
                default: nxt_state = IDLE;
            endcase
        end
    end

    // Line levels are computed for the upcoming quarter so they can be registered
    always_comb begin
        wsh = wdat_r << {nxt_byte, 3'b000};
        unique case (nxt_state)
            ADDR_W:  tx_byte = {addr_r, 1'b0};
            PTR:     tx_byte = ptr_r;
            WDATA:   tx_byte = wsh[W-1 -: 8];
            ADDR_R:  tx_byte = {addr_r, 1'b1};
            default: tx_byte = 8'h00;
        endcase
        tx_bit = tx_byte[3'd7 - nxt_bit];

        nxt_scl_low = !nxt_q[1];
        nxt_sda_low = 1'b0;
        unique case (nxt_state)
            IDLE, DONE: nxt_scl_low = 1'b0;
            START: begin
                nxt_scl_low = (nxt_q == 2'd3);
                nxt_sda_low = nxt_q[1];
            end
            // SCL is pulled low first so the slave can release its ACK before SDA rises
            RSTART: begin
                nxt_scl_low = (nxt_q == 2'd0) || (nxt_q == 2'd3);
                nxt_sda_low = nxt_q[1];
            end
            STOP: begin
                nxt_scl_low = (nxt_q == 2'd0);
                nxt_sda_low = (nxt_q != 2'd3);
            end
            ADDR_W, PTR, WDATA, ADDR_R: nxt_sda_low = !tx_bit;
            MACK:    nxt_sda_low = (nxt_byte != LAST_BYTE);
            default: nxt_sda_low = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            q        <= 2'd0;
            div_cnt  <= '0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
            hold     <= 1'b0;
            rw_r     <= 1'b0;
            addr_r   <= 7'd0;
            ptr_r    <= 8'd0;
            wdat_r   <= '0;
            rx_sh    <= '0;
            line_s   <= 1'b1;
            sda_low  <= 1'b0;
            scl_low  <= 1'b0;
            busy     <= 1'b0;
            eot      <= 1'b0;
            nack     <= 1'b0;
            data_out <= '0;
        end else begin
            sda_low <= nxt_sda_low;
            scl_low <= nxt_scl_low;
            eot     <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    rw_r     <= rd_wr;
                    addr_r   <= slv_addr_in;
                    ptr_r    <= pointer_addr;
                    wdat_r   <= data_in;
                    busy     <= 1'b1;
                    nack     <= 1'b0;
                    hold     <= 1'b1;
                    state    <= START;
                    q        <= 2'd0;
                    div_cnt  <= '0;
                    bit_cnt  <= 3'd0;
                    byte_cnt <= 2'd0;
                end
            end else begin
                hold     <= 1'b0;
                state    <= nxt_state;
                q        <= nxt_q;
                div_cnt  <= nxt_div;
                bit_cnt  <= nxt_bit;
                byte_cnt <= nxt_byte;
                if (nack_set)
                    nack <= 1'b1;
                if (samp) begin
                    line_s <= sda;
                    if (state == RDATA)
                        rx_sh <= {rx_sh[W-2:0], sda};
                end
                if (state == STOP && nxt_state == DONE) begin
                    eot  <= 1'b1;
                    busy <= 1'b0;
                    if (rw_r && !nack)
                        data_out <= rx_sh;
                end
            end
        end
    end

endmodule

// File: doc/i2c_master_nbyte.md
Name: i2c_master_nbyte

Overview:
- Parametrised successor to the team's 16-bit I2C register master; drives one I2C bus (SDA/SCL, open-drain) to register-mapped sensors such as the INA219.
- Transfer size is DATA_BYTES bytes and the SCL rate comes from a divider parameter.
- Reads run as one combined transaction: pointer write, repeated START, then data read. Host does not issue two commands.
- Slave NACK is detected and aborts the transfer.

Parameters:
- DATA_BYTES, 2, data bytes per transfer (1..4); data width is 8*DATA_BYTES.
- CLK_DIV, 4, clk cycles per SCL quarter-period (>=1); one bit period = 4*CLK_DIV clocks.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  transfer request; sampled only in IDLE.
- rd_wr  input  1  0 = register write, 1 = register read.
- slv_addr_in  input  7  7-bit slave address.
- pointer_addr  input  8  register pointer byte.
- data_in  input  8*DATA_BYTES  write data; MSB byte sent first.
- data_out  output  8*DATA_BYTES  read data; first received byte lands in the MSBs.
- busy  output  1  transfer in progress.
- eot  output  1  one-cycle end-of-transfer pulse.
- nack  output  1  last transfer was aborted by a slave NACK.
- sda  inout  1  driven 0 or released (z); external pull-up.
- scl  inout  1  driven 0 or released (z); external pull-up; no clock stretching.

Behaviour:
- Reset (async, rst=0): state IDLE; sda=z, scl=z; busy=0, eot=0, nack=0, data_out=0; divider and bit counters cleared. Assertion mid-transfer releases both lines immediately, with no STOP generated.
- Command acceptance: in IDLE, start=1 latches rd_wr, slv_addr_in, pointer_addr and data_in. busy=1 from the next clock and nack is cleared. start while busy is ignored.
- Bit timing: quarter-phase counter advances every CLK_DIV clocks.
  - q0/q1: SCL low; SDA changes at q0 entry.
  - q2/q3: SCL released.
  - SDA sampled on the last clock of q2.
- States: IDLE, START, ADDR_W, ACK1, PTR, ACK2, WDATA, ACK3, RSTART, ADDR_R, ACK4, RDATA, MACK, STOP, DONE.
- Write sequence: START, {addr,0}, ACK, pointer, ACK, then DATA_BYTES bytes MSB-first, each followed by a slave ACK, then STOP.
- Read sequence: START, {addr,0}, ACK, pointer, ACK, RSTART, {addr,1}, ACK, then DATA_BYTES bytes.
  - Master ACKs (SDA=0) every byte except the last.
  - Master NACKs the last byte (SDA=z), then STOP.
- START/RSTART: SDA high with SCL high, then SDA falls while SCL high, then SCL low. Lasts one bit period.
- STOP: SDA low, SCL released, then SDA released while SCL high. Lasts one bit period.
- Slave ACK check: SDA sampled as 1 in any ACK state sets nack=1 and jumps to STOP. Remaining bytes are skipped and data_out is unchanged.
- Completion: DONE lasts one clock with eot=1 and busy=0, then the block returns to IDLE. A new start is accepted from the clock after eot.
- data_out is updated only at eot of a successful read and otherwise holds its value.
- Latency from start sample to eot, in bit periods × 4*CLK_DIV, +1 clock:
  - Write: 2 + 9*(2+DATA_BYTES).
  - Read: 3 + 9*(3+DATA_BYTES).
  - NACK at the address byte: 11.

Test Plan:
- Write, defaults: slv 0x01, ptr 0xAA, data 0x3955 -> bus bytes 0x02, 0xAA, 0x39, 0x55, all ACKed; STOP; eot at 38*16+1 = 609 clocks after start; nack=0.
- Read, defaults: slave model returns 0x1234 for ptr 0x81 -> bus 0x02, 0x81, Sr, 0x03; master ACK after 0x12, NACK after 0x34; data_out=0x1234 at eot (48*16+1 clocks).
- Address NACK: slv 0x22 with no responder -> nack=1; STOP follows the first ACK slot; eot at 11*16+1 clocks; data_out keeps 0x1234.
- start pulsed during a transfer with different data -> ignored; bus shows only the original bytes; exactly one eot.
- rst low mid-PTR byte -> sda and scl both z in the same cycle; busy=0; next write completes normally.
- DATA_BYTES=4, CLK_DIV=1: read returning 0xDEADBEEF -> data_out=0xDEADBEEF; three master ACKs and one final NACK; bit period 4 clocks.
